// File: rtl/asr_pkg.sv
// asr_pkg: shared state type, width helpers and circular tap addressing for asr_mc.
// No ports. cw(n) gives an index width of at least 1 bit.
// wrap_dec(ptr, off, n) gives (ptr-1-off) mod n for a ring of depth n.
package asr_pkg;
  typedef enum logic {IDLE, SWEEP} state_e;
  localparam int MIN_W = 1;
  function automatic int cw(input int n);
    return n > 1 ? $clog2(n) : MIN_W;
  endfunction
  function automatic int wrap_dec(input int ptr, input int off, input int n);
    int s;
    s = ptr - 1 - off;
    if (s < 0) s = s + n;
    if (s < 0) s = s + n;
    return s;
  endfunction
endpackage

// File: rtl/asr_mc_if.sv
// asr_mc_if: input, tap-stream and random-read signals of asr_mc.
// Input side: in_valid/in_ready/in_ch/in_data. Tap side: out_valid/out_ready/out_data/out_tap/out_ch/out_last.
// Read side: rd_ch/rd_add/rd_q. flush exists only when ASR_FLUSH_EN is defined.
// master = driver of samples and consumer of taps; slave = asr_mc.
interface asr_mc_if #(parameter int WIDTH_DATA = 8, parameter int N_TAPS = 16, parameter int N_CH = 2);
  localparam int CW = asr_pkg::cw(N_CH);
  localparam int TW = asr_pkg::cw(N_TAPS);
  logic in_valid, in_ready, out_valid, out_ready, out_last;
  logic [CW-1:0] in_ch, out_ch, rd_ch;
  logic [WIDTH_DATA-1:0] in_data, out_data, rd_q;
  logic [TW-1:0] out_tap, rd_add;
`ifdef ASR_FLUSH_EN
  logic flush;
  modport master (output in_valid, in_ch, in_data, out_ready, rd_ch, rd_add, flush,
                  input in_ready, out_valid, out_data, out_tap, out_ch, out_last, rd_q);
  modport slave (input in_valid, in_ch, in_data, out_ready, rd_ch, rd_add, flush,
                 output in_ready, out_valid, out_data, out_tap, out_ch, out_last, rd_q);
`else
  modport master (output in_valid, in_ch, in_data, out_ready, rd_ch, rd_add,
                  input in_ready, out_valid, out_data, out_tap, out_ch, out_last, rd_q);
  modport slave (input in_valid, in_ch, in_data, out_ready, rd_ch, rd_add,
                 output in_ready, out_valid, out_data, out_tap, out_ch, out_last, rd_q);
`endif
endinterface

// File: rtl/asr_chan_buf.sv
// asr_chan_buf: one channel's circular history buffer with write pointer and tap-to-address mapping.
// Ports: clk, clr (async active-low), we/d write, tap->q sweep read, rd_add->rd_q debug read
// (0 when rd_add >= N_TAPS), flush (only with ASR_FLUSH_EN) clears all entries and the pointer.
module asr_chan_buf import asr_pkg::*; #(
  parameter int WIDTH_DATA = 8,
  parameter int N_TAPS = 16
) (
  input  logic                  clk,
  input  logic                  clr,
  input  logic                  we,
`ifdef ASR_FLUSH_EN
  input  logic                  flush,
`endif
  input  logic [WIDTH_DATA-1:0] d,
  input  logic [cw(N_TAPS)-1:0] tap,
  output logic [WIDTH_DATA-1:0] q,
  input  logic [cw(N_TAPS)-1:0] rd_add,
  output logic [WIDTH_DATA-1:0] rd_q
);
  localparam int TW = cw(N_TAPS);
  logic [WIDTH_DATA-1:0] mem_q [N_TAPS];
  logic [WIDTH_DATA-1:0] mem_d [N_TAPS];
  logic [TW-1:0] wp_q, wp_d;
  logic fl;
`ifdef ASR_FLUSH_EN
  assign fl = flush;
`else
  assign fl = 1'b0;
`endif
  always_comb begin
    mem_d = mem_q;
    wp_d = wp_q;
    if (fl) begin
      for (int i = 0; i < N_TAPS; i++) mem_d[i] = '0;
      wp_d = '0;
    end else if (we) begin
      mem_d[wp_q] = d;
      wp_d = int'(wp_q) == N_TAPS - 1 ? '0 : wp_q + 1'b1;
    end
  end
  always_ff @(posedge clk or negedge clr)
    if (!clr) begin
      for (int i = 0; i < N_TAPS; i++) mem_q[i] <= '0;
      wp_q <= '0;
    end else begin
      mem_q <= mem_d;
      wp_q <= wp_d;
    end
  assign q = mem_q[TW'(wrap_dec(int'(wp_q), int'(tap), N_TAPS))];
  assign rd_q = int'(rd_add) < N_TAPS ? mem_q[TW'(wrap_dec(int'(wp_q), int'(rd_add), N_TAPS))] : '0;
endmodule

// File: rtl/asr_mc.sv
// asr_mc: multi-channel addressable shift register streaming each channel's tap history after every input.
// Ports: clk, clr (async active-low), bus (asr_mc_if.slave): sample input, tap stream, random read.
// Optional ASR_FLUSH_EN adds bus.flush, clearing all history in one IDLE cycle.
module asr_mc import asr_pkg::*; #(
  parameter int WIDTH_DATA = 8,
  parameter int N_TAPS = 16,
  parameter int N_CH = 2
) (
  input logic clk,
  input logic clr,
  asr_mc_if.slave bus
);
  localparam int CW = cw(N_CH);
  localparam int TW = cw(N_TAPS);
  state_e state_q, state_d;
  logic out_valid_q, out_valid_d, out_last_q, out_last_d, pend_q, pend_d;
  logic [TW-1:0] out_tap_q, out_tap_d;
  logic [CW-1:0] out_ch_q, out_ch_d;
  logic [WIDTH_DATA-1:0] tap_q [N_CH];
  logic [WIDTH_DATA-1:0] rdq [N_CH];
  logic [N_CH-1:0] we;
  logic fl_in, fl_now, do_fl, accept, ch_ok;
`ifdef ASR_FLUSH_EN
  assign fl_in = bus.flush;
`else
  assign fl_in = 1'b0;
`endif
  // A flush seen mid-sweep is remembered and executed on the first IDLE cycle; it blocks input meanwhile.
  assign fl_now = fl_in || pend_q;
  assign do_fl = fl_now && state_q == IDLE;
  assign ch_ok = int'(bus.in_ch) < N_CH;
  assign bus.in_ready = !fl_now && (state_q == IDLE || (out_last_q && bus.out_ready));
  assign accept = bus.in_valid && bus.in_ready;
  for (genvar c = 0; c < N_CH; c++) begin : g_ch
    assign we[c] = accept && ch_ok && int'(bus.in_ch) == c;
    asr_chan_buf #(.WIDTH_DATA(WIDTH_DATA), .N_TAPS(N_TAPS)) u_buf (
      .clk(clk),
      .clr(clr),
      .we(we[c]),
`ifdef ASR_FLUSH_EN
      .flush(do_fl),
`endif
      .d(bus.in_data),
      .tap(out_tap_q),
      .q(tap_q[c]),
      .rd_add(bus.rd_add),
      .rd_q(rdq[c])
    );
  end
  always_comb begin
    state_d = state_q;
    out_valid_d = out_valid_q;
    out_last_d = out_last_q;
    out_tap_d = out_tap_q;
    out_ch_d = out_ch_q;
    pend_d = state_q == SWEEP && (pend_q || fl_in);
    if (state_q == SWEEP && bus.out_ready) begin
      state_d = out_last_q ? IDLE : SWEEP;
      out_valid_d = !out_last_q;
      out_tap_d = out_last_q ? '0 : out_tap_q + 1'b1;
      out_last_d = !out_last_q && int'(out_tap_q) == N_TAPS - 2;
    end
    if (accept && ch_ok) begin
      state_d = SWEEP;
      out_valid_d = 1'b1;
      out_ch_d = bus.in_ch;
      out_tap_d = '0;
      out_last_d = 1'b0;
    end
  end
  always_ff @(posedge clk or negedge clr)
    if (!clr) begin
      state_q <= IDLE;
      out_valid_q <= 1'b0;
      out_last_q <= 1'b0;
      out_tap_q <= '0;
      out_ch_q <= '0;
      pend_q <= 1'b0;
    end else begin
      state_q <= state_d;
      out_valid_q <= out_valid_d;
      out_last_q <= out_last_d;
      out_tap_q <= out_tap_d;
      out_ch_q <= out_ch_d;
      pend_q <= pend_d;
    end
  assign bus.out_valid = out_valid_q;
  assign bus.out_last = out_last_q;
  assign bus.out_tap = out_tap_q;
  assign bus.out_ch = out_ch_q;
  assign bus.out_data = out_valid_q ? tap_q[out_ch_q] : '0;
  assign bus.rd_q = int'(bus.rd_ch) < N_CH ? rdq[bus.rd_ch] : '0;
endmodule

// File: tb/tb_asr_mc.sv
// tb_asr_mc: directed and randomized checks of asr_mc against a newest-first history model.
module tb_asr_mc;
  localparam int W = 8, NT = 16, NC = 2, CW = 1, TW = 4;
  logic clk = 0, clr = 0;
  int cmps = 0, errs = 0;
  logic [W-1:0] hist [NC][NT];
  always #5 clk = ~clk;
  asr_mc_if #(.WIDTH_DATA(W), .N_TAPS(NT), .N_CH(NC)) bus ();
  asr_mc #(.WIDTH_DATA(W), .N_TAPS(NT), .N_CH(NC)) dut (.clk(clk), .clr(clr), .bus(bus));
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    cmps++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic model_write(input int ch, input logic [W-1:0] d);
    for (int i = NT - 1; i > 0; i--) hist[ch][i] = hist[ch][i-1];
    hist[ch][0] = d;
  endtask
  task automatic model_clear;
    for (int c = 0; c < NC; c++) for (int i = 0; i < NT; i++) hist[c][i] = '0;
  endtask
  task automatic push(input int ch, input logic [W-1:0] d);
    int g = 0;
    @(negedge clk);
    while (!bus.in_ready && g < 100) begin
      @(negedge clk);
      g++;
    end
    check("push_ready", 32'(bus.in_ready), 32'd1);
    bus.in_valid = 1;
    bus.in_ch = CW'(ch);
    bus.in_data = d;
    @(posedge clk);
    model_write(ch, d);
    @(negedge clk);
    bus.in_valid = 0;
  endtask
  // mode 0: always ready, 1: random ready, 2: repeating ready pattern 1,0,0,1
  task automatic sweep(input int ch, input int mode, input bit chain, input int nch, input logic [W-1:0] nd);
    int t = 0, g = 0;
    logic rdy;
    while (t < NT && g < 400) begin
      rdy = mode == 1 ? 1'($urandom_range(0, 1)) : mode == 2 ? (g % 4 == 0 || g % 4 == 3) : 1'b1;
      g++;
      if (chain && t == NT - 1) begin
        rdy = 1;
        bus.in_valid = 1;
        bus.in_ch = CW'(nch);
        bus.in_data = nd;
      end
      bus.out_ready = rdy;
      #1;
      check("out_valid", 32'(bus.out_valid), 32'd1);
      check("out_tap", 32'(bus.out_tap), 32'(t));
      check("out_ch", 32'(bus.out_ch), 32'(ch));
      check("out_data", 32'(bus.out_data), 32'(hist[ch][t]));
      check("out_last", 32'(bus.out_last), 32'(t == NT - 1));
      check("sweep_in_ready", 32'(bus.in_ready), 32'(t == NT - 1 && rdy));
      @(posedge clk);
      if (rdy) begin
        if (chain && t == NT - 1) model_write(nch, nd);
        t++;
      end
      @(negedge clk);
      bus.in_valid = 0;
    end
    check("sweep_beats", 32'(t), 32'(NT));
  endtask
  task automatic idle_check;
    #1;
    check("idle_out_valid", 32'(bus.out_valid), 32'd0);
    check("idle_in_ready", 32'(bus.in_ready), 32'd1);
  endtask
  task automatic rd_all;
    for (int c = 0; c < NC; c++)
      for (int t = 0; t < NT; t++) begin
        bus.rd_ch = CW'(c);
        bus.rd_add = TW'(t);
        #1;
        check("rd_q", 32'(bus.rd_q), 32'(hist[c][t]));
      end
  endtask
  initial begin
    int c, nc;
    logic [W-1:0] d, nd;
    bus.in_valid = 0;
    bus.in_ch = 0;
    bus.in_data = 0;
    bus.out_ready = 0;
    bus.rd_ch = 0;
    bus.rd_add = 0;
`ifdef ASR_FLUSH_EN
    bus.flush = 0;
`endif
    model_clear();
    #12;
    check("rst_out_valid", 32'(bus.out_valid), 32'd0);
    check("rst_out_last", 32'(bus.out_last), 32'd0);
    check("rst_out_tap", 32'(bus.out_tap), 32'd0);
    check("rst_out_ch", 32'(bus.out_ch), 32'd0);
    check("rst_out_data", 32'(bus.out_data), 32'd0);
    @(negedge clk);
    clr = 1;
    @(negedge clk);
    #1;
    check("rst_in_ready", 32'(bus.in_ready), 32'd1);
    push(0, 8'h55);
    sweep(0, 0, 0, 0, 0);
    idle_check();
    for (int i = 1; i <= 20; i++) begin
      push(0, W'(i));
      sweep(0, 0, 0, 0, 0);
    end
    bus.rd_ch = 0;
    bus.rd_add = 15;
    #1;
    check("rd_wrap_tap15", 32'(bus.rd_q), 32'h5);
    rd_all();
    push(0, 8'h10);
    for (int k = 0; k < 6; k++)
      sweep(k % 2, 0, k < 5, (k + 1) % 2, (k % 2 == 1) ? 8'h10 : 8'hA0);
    idle_check();
    push(1, 8'h77);
    sweep(1, 2, 0, 0, 0);
    idle_check();
    c = $urandom_range(0, NC - 1);
    push(c, W'($urandom));
    for (int j = 0; j < 20; j++) begin
      nc = $urandom_range(0, NC - 1);
      nd = W'($urandom);
      sweep(c, 1, j < 19, nc, nd);
      c = nc;
    end
    idle_check();
    rd_all();
    push(0, 8'h99);
    bus.out_ready = 1;
    repeat (7) @(negedge clk);
    #1;
    check("pre_clr_tap", 32'(bus.out_tap), 32'd7);
    check("pre_clr_valid", 32'(bus.out_valid), 32'd1);
    clr = 0;
    #1;
    check("clr_out_valid", 32'(bus.out_valid), 32'd0);
    check("clr_out_tap", 32'(bus.out_tap), 32'd0);
    model_clear();
    @(negedge clk);
    clr = 1;
    @(negedge clk);
    #1;
    check("post_clr_in_ready", 32'(bus.in_ready), 32'd1);
    rd_all();
`ifdef ASR_FLUSH_EN
    for (int i = 0; i < NT; i++) begin
      push(1, 8'hFF);
      sweep(1, 0, 0, 0, 0);
    end
    @(negedge clk);
    bus.flush = 1;
    #1;
    check("flush_in_ready", 32'(bus.in_ready), 32'd0);
    @(posedge clk);
    model_clear();
    @(negedge clk);
    bus.flush = 0;
    push(1, 8'h3C);
    sweep(1, 0, 0, 0, 0);
    rd_all();
`endif
    d = 0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmps, errs + int'(d));
    $finish;
  end
endmodule
